// File: rtl/cpu4_pkg.sv
// Shared definitions for the CPU4 data-RAM arbiter.
//   CPU4_AW     : default RAM word-address width
//   CPU4_DW     : default data word width (matches rx / P width)
//   arb_state_t : arbiter FSM state encoding
package cpu4_pkg;

    localparam int CPU4_AW = 8;
    localparam int CPU4_DW = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way request picker.
//   req0, req1  : pending requests
//   last_winner : port granted by the previous decision
//   rr_en       : 1 = alternate on contention, 0 = port 0 always wins
//   sel         : chosen port (meaningful only when req0 | req1)
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_winner,
    input  logic rr_en,
    output logic sel
);

    always_comb begin
        sel = 1'b0;
        if (req0 && req1) begin
            // On contention the port that did not win last time goes next.
            sel = rr_en ? ~last_winner : 1'b0;
        end else if (req1) begin
            sel = 1'b1;
        end
    end

endmodule

// File: rtl/cpu4_mem_arbiter.sv
// Shares one single-port synchronous data RAM between the CPU4 load/store
// unit (port 0) and the rx capture path (port 1). One access is issued every
// two clocks at most: IDLE picks a winner and latches its request, ISSUE
// drives the RAM for exactly one cycle.
//   clk, rst             : clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*: per-port request, held until the matching gnt
//   gnt0/gnt1            : one-cycle pulse in the cycle the RAM is driven
//   rvalid0/rvalid1      : one-cycle pulse, rdata carries that port's read
//   rdata                : shared read-data bus, holds its last value
//   mem_*                : RAM interface, all zero outside the issue cycle
module cpu4_mem_arbiter
    import cpu4_pkg::*;
#(
    parameter int AW    = CPU4_AW,
    parameter int DW    = CPU4_DW,
    parameter bit RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    state_reg, state_next;
    logic          last_winner_reg, last_winner_next;
    logic          gnt0_reg, gnt0_next;
    logic          gnt1_reg, gnt1_next;
    logic          rvalid0_reg, rvalid0_next;
    logic          rvalid1_reg, rvalid1_next;
    logic          mem_en_reg, mem_en_next;
    logic          mem_we_reg, mem_we_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
    logic [DW-1:0] rdata_hold_reg, rdata_hold_next;
    logic          sel;
    logic          rd_ret;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_winner (last_winner_reg),
        .rr_en       (RR_EN),
        .sel         (sel)
    );

    // A read result is on mem_rdata in the cycle after ISSUE; rdata passes it
    // straight through then and otherwise shows the captured copy.
    assign rd_ret = rvalid0_reg | rvalid1_reg;

    always_comb begin
        state_next       = state_reg;
        last_winner_next = last_winner_reg;
        gnt0_next        = 1'b0;
        gnt1_next        = 1'b0;
        rvalid0_next     = 1'b0;
        rvalid1_next     = 1'b0;
        mem_en_next      = 1'b0;
        mem_we_next      = 1'b0;
        mem_addr_next    = '0;
        mem_wdata_next   = '0;
        rdata_hold_next  = rd_ret ? mem_rdata : rdata_hold_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // The mem_* registers double as the latched request, so
                    // a requester dropping req during ISSUE has no effect.
                    state_next       = ST_ISSUE;
                    last_winner_next = sel;
                    gnt0_next        = ~sel;
                    gnt1_next        = sel;
                    mem_en_next      = 1'b1;
                    mem_we_next      = sel ? we1 : we0;
                    mem_addr_next    = sel ? addr1 : addr0;
                    mem_wdata_next   = sel ? wdata1 : wdata0;
                end
            end
            ST_ISSUE: begin
                state_next   = ST_IDLE;
                rvalid0_next = ~mem_we_reg & gnt0_reg;
                rvalid1_next = ~mem_we_reg & gnt1_reg;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            last_winner_reg <= 1'b1;
            gnt0_reg        <= 1'b0;
            gnt1_reg        <= 1'b0;
            rvalid0_reg     <= 1'b0;
            rvalid1_reg     <= 1'b0;
            mem_en_reg      <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            rdata_hold_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            last_winner_reg <= last_winner_next;
            gnt0_reg        <= gnt0_next;
            gnt1_reg        <= gnt1_next;
            rvalid0_reg     <= rvalid0_next;
            rvalid1_reg     <= rvalid1_next;
            mem_en_reg      <= mem_en_next;
            mem_we_reg      <= mem_we_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            rdata_hold_reg  <= rdata_hold_next;
        end
    end

    assign gnt0      = gnt0_reg;
    assign gnt1      = gnt1_reg;
    assign rvalid0   = rvalid0_reg;
    assign rvalid1   = rvalid1_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign rdata     = rd_ret ? mem_rdata : rdata_hold_reg;

endmodule

// File: tb/tb_cpu4_mem_arbiter.sv
// Directed bench for cpu4_mem_arbiter: round-robin instance u_dut with a
// synchronous RAM model, plus a fixed-priority instance u_fix sharing the
// request inputs and used for the contention grant order.
module tb_cpu4_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;

    logic        gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    logic        f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_mem_en, f_mem_we;
    logic [15:0] f_rdata, f_mem_wdata;
    logic [15:0] f_mem_rdata = '0;
    logic [7:0]  f_mem_addr;

    logic [15:0] ram [0:255];
    logic [7:0]  rd_addr_q = '0;
    int          wr_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    cpu4_mem_arbiter #(.AW(8), .DW(16), .RR_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    cpu4_mem_arbiter #(.AW(8), .DW(16), .RR_EN(1'b0)) u_fix (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .rvalid0(f_rvalid0), .rvalid1(f_rvalid1),
        .rdata(f_rdata), .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
    );

    // Single-port synchronous RAM, read data one clock after the enable.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol invariants and read scoreboard against the RAM model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("gnt_mutex", 32'(gnt0 & gnt1), 32'd0);
            chk("rvalid_mutex", 32'(rvalid0 & rvalid1), 32'd0);
            chk("mem_en_only_issue", 32'(mem_en), 32'(gnt0 | gnt1));
            chk("fix_gnt_mutex", 32'(f_gnt0 & f_gnt1), 32'd0);
            if (mem_en && mem_we)  wr_cnt <= wr_cnt + 1;
            if (mem_en && !mem_we) rd_addr_q <= mem_addr;
            if (rvalid0 || rvalid1) chk("rdata_vs_ram", 32'(rdata), 32'(ram[rd_addr_q]));
        end
    end

    initial begin
        int snap;

        // 1: reset with both requests pending, then first grant goes to port 0
        #1 rst = 1'b0;
        mon_en = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 16'h1234;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h21; wdata1 = 16'h5678;
        repeat (3) tick();
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_bus", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b1;
        tick();
        chk("first_gnt0", 32'(gnt0), 32'd1);
        chk("first_gnt1", 32'(gnt1), 32'd0);
        chk("first_addr", 32'(mem_addr), 32'h20);
        chk("first_wdata", 32'(mem_wdata), 32'h1234);
        chk("fix_first_gnt0", 32'(f_gnt0), 32'd1);
        $display("txn reset_release gnt0=%0b addr=%0h", gnt0, mem_addr);
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) tick();

        // 2: single write from port 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 16'haaaa;
        tick();
        chk("wr_gnt1", 32'(gnt1), 32'd1);
        chk("wr_gnt0", 32'(gnt0), 32'd0);
        chk("wr_mem_en", 32'(mem_en), 32'd1);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'h10);
        chk("wr_wdata", 32'(mem_wdata), 32'haaaa);
        $display("txn write p1 addr=%0h data=%0h", mem_addr, mem_wdata);
        req1 = 1'b0;
        tick();
        chk("wr_no_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("wr_mem_idle", 32'(mem_en), 32'd0);
        tick();

        // 3: read back from port 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        tick();
        chk("rd_gnt0", 32'(gnt0), 32'd1);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("rd_addr", 32'(mem_addr), 32'h10);
        req0 = 1'b0;
        tick();
        chk("rd_rvalid0", 32'(rvalid0), 32'd1);
        chk("rd_rvalid1", 32'(rvalid1), 32'd0);
        chk("rd_rdata", 32'(rdata), 32'haaaa);
        $display("txn read p0 addr=10 data=%0h", rdata);
        tick();
        chk("rd_rvalid_pulse", 32'(rvalid0), 32'd0);
        chk("rd_rdata_hold", 32'(rdata), 32'haaaa);

        // port 1 write so that port 0 is next on contention
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h30; wdata1 = 16'h5555;
        tick();
        chk("pre_gnt1", 32'(gnt1), 32'd1);
        chk("pre_wdata", 32'(mem_wdata), 32'h5555);
        req1 = 1'b0;
        repeat (2) tick();

        // 4: contention, both held for 8 cycles
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 16'h0101;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h41; wdata1 = 16'h0202;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("rr_gnt0_c%0d", i), 32'(gnt0), 32'((i % 4) == 1));
            chk($sformatf("rr_gnt1_c%0d", i), 32'(gnt1), 32'((i % 4) == 3));
            chk($sformatf("fix_gnt0_c%0d", i), 32'(f_gnt0), 32'((i % 2) == 1));
            chk($sformatf("fix_gnt1_c%0d", i), 32'(f_gnt1), 32'd0);
            if (gnt0 || gnt1) $display("txn contention c%0d rr_gnt=%0b%0b fix_gnt=%0b%0b",
                                       i, gnt1, gnt0, f_gnt1, f_gnt0);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) tick();

        // 5: req0 drops during ISSUE; the write still completes exactly once
        snap = wr_cnt;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h50; wdata0 = 16'hbeef;
        tick();
        chk("late_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        repeat (3) tick();
        chk("late_wr_once", 32'(wr_cnt - snap), 32'd1);
        chk("late_ram", 32'(ram[8'h50]), 32'hbeef);
        $display("txn late_drop writes=%0d", wr_cnt - snap);
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h50;
        tick();
        chk("late_rd_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        tick();
        chk("late_rd_rvalid1", 32'(rvalid1), 32'd1);
        chk("late_rd_rdata", 32'(rdata), 32'hbeef);
        $display("txn read p1 addr=50 data=%0h", rdata);
        tick();

        // 6: reset during the ISSUE cycle of a read
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        tick();
        chk("mid_gnt0", 32'(gnt0), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_mem_en_clr", 32'(mem_en), 32'd0);
        chk("mid_gnt0_clr", 32'(gnt0), 32'd0);
        req0 = 1'b0;
        tick();
        chk("mid_no_rvalid", 32'(rvalid0), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_mem_en_%0d", i), 32'(mem_en), 32'd0);
            chk($sformatf("post_rvalid0_%0d", i), 32'(rvalid0), 32'd0);
        end
        $display("txn reset_mid_read done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
